prescaled_step_timer: RTL and testbench

//  Parametrised tick/step timer for game pacing and score timing. A runtime-

---
 rtl/prescaled_step_timer.sv | 116 +++++++++++
 tb/tb_prescaled_step_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prescaled_step_timer.sv
// prescaled_step_timer
// Runtime-programmable prescaler that produces tick pulses. Each tick
// advances a step counter, which either wraps at a limit or stops there
// (one-shot). The counter can be paused without losing progress and
// cleared synchronously.
//
// Handshake: this block has no valid/ready interface. run is a plain level
// enable sampled every edge. tick and wrap are single-cycle registered
// pulses, and done and busy are registered levels. No input reaches an
// output combinationally.
module prescaled_step_timer #(
  parameter int CNT_W   = 13,
  parameter int DIV_W   = 8,
  parameter int ONESHOT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] limit,
  output logic             tick,
  output logic             wrap,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] step_val,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] pre;
  logic [DIV_W-1:0] div_m1;
  logic             period_end;
  logic             below_limit;
  logic [CNT_W-1:0] step_inc;
  logic             hits_limit;

  // Terminal prescaler count. A div of 0 behaves like 1, so every advancing
  // edge ticks. The >= test lets a mid-period div decrease take effect on
  // the next advancing edge instead of running the counter past the end.
  always_comb begin
    div_m1      = (div == '0) ? '0 : div - 1'b1;
    period_end  = (pre >= div_m1);
    below_limit = (step_val < limit);
    step_inc    = step_val + 1'b1;
    hits_limit  = (step_inc == limit);
  end

  // Main control: prescaler, step counter, FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      pre      <= '0;
      step_val <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      done     <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      pre      <= '0;
      step_val <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      done     <= 1'b0;
    end else if (state == DONE) begin
      // Terminal hold: only clear or reset leaves DONE.
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (run) begin
      if (period_end) begin
        pre  <= '0;
        tick <= 1'b1;
        if (below_limit) begin
          // step_val < limit, so step_inc cannot overflow.
          step_val <= step_inc;
          wrap     <= 1'b0;
          if ((ONESHOT != 0) && hits_limit) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= RUN;
          end
        end else if (ONESHOT == 0) begin
          // At or past the limit, which also covers a limit lowered mid-run.
          step_val <= '0;
          wrap     <= 1'b1;
          state    <= RUN;
        end else begin
          wrap  <= 1'b0;
          state <= DONE;
          done  <= 1'b1;
        end
      end else begin
        pre   <= pre + 1'b1;
        tick  <= 1'b0;
        wrap  <= 1'b0;
        state <= RUN;
      end
    end else begin
      // Pause: the prescaler and step counter are held, not cleared.
      state <= IDLE;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end
  end

  assign busy      = (state == RUN);
  assign dbg_state = state;

endmodule

// File: tb/tb_prescaled_step_timer.sv
// tb_prescaled_step_timer
// Drives a wrapping instance and a one-shot instance from shared inputs. A
// timer model in the bench, described by tick and step rules, predicts both
// instances every cycle. Directed scenarios come first, followed by a
// randomized soak.
module tb_prescaled_step_timer;

  localparam int CNT_W = 13;
  localparam int DIV_W = 8;

  // Clock and reset signals
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, run, clear;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] limit;

  logic             tick0, wrap0, done0, busy0;
  logic [CNT_W-1:0] step0;
  logic [1:0]       st0;
  logic             tick1, wrap1, done1, busy1;
  logic [CNT_W-1:0] step1;
  logic [1:0]       st1;

  prescaled_step_timer #(.CNT_W(CNT_W), .DIV_W(DIV_W), .ONESHOT(0)) u_wrap (
    .clk(clk), .rst(rst), .run(run), .clear(clear), .div(div), .limit(limit),
    .tick(tick0), .wrap(wrap0), .done(done0), .busy(busy0), .step_val(step0),
    .dbg_state(st0)
  );

  prescaled_step_timer #(.CNT_W(CNT_W), .DIV_W(DIV_W), .ONESHOT(1)) u_one (
    .clk(clk), .rst(rst), .run(run), .clear(clear), .div(div), .limit(limit),
    .tick(tick1), .wrap(wrap1), .done(done1), .busy(busy1), .step_val(step1),
    .dbg_state(st1)
  );

  int errors = 0;
  int checks = 0;

  // Reference timer, one entry per mode (index 0 wraps, index 1 is one-shot).
  // Mode values: 0 means idle, 1 means running, 2 means finished.
  int m_phase [2];
  int m_step  [2];
  int m_mode  [2];
  bit m_tick  [2];
  bit m_wrap  [2];
  bit m_done  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock edge, using the inputs presented at
  // that edge.
  task automatic model_edge();
    int period;
    for (int m = 0; m < 2; m++) begin
      if (!rst || clear) begin
        m_phase[m] = 0; m_step[m] = 0; m_mode[m] = 0;
        m_tick[m] = 0;  m_wrap[m] = 0; m_done[m] = 0;
      end else if (m_mode[m] == 2) begin
        m_tick[m] = 0; m_wrap[m] = 0;
      end else if (!run) begin
        m_mode[m] = 0; m_tick[m] = 0; m_wrap[m] = 0;
      end else begin
        period = (int'(div) == 0) ? 1 : int'(div);
        m_mode[m] = 1;
        m_wrap[m] = 0;
        m_phase[m] = m_phase[m] + 1;
        m_tick[m] = (m_phase[m] >= period);
        if (m_tick[m]) begin
          m_phase[m] = 0;
          if (m_step[m] < int'(limit)) begin
            m_step[m] = m_step[m] + 1;
            if (m == 1 && m_step[m] == int'(limit)) begin
              m_mode[m] = 2; m_done[m] = 1;
            end
          end else if (m == 0) begin
            m_step[m] = 0; m_wrap[m] = 1;
          end else begin
            m_mode[m] = 2; m_done[m] = 1;
          end
        end
      end
    end
  endtask

  // Scoreboard: compares both instances against the model.
  task automatic compare_all();
    chk("w.tick", 32'(tick0), 32'(m_tick[0]));
    chk("w.wrap", 32'(wrap0), 32'(m_wrap[0]));
    chk("w.done", 32'(done0), 32'(m_done[0]));
    chk("w.busy", 32'(busy0), 32'(m_mode[0] == 1));
    chk("w.step", 32'(step0), 32'(m_step[0]));
    chk("o.tick", 32'(tick1), 32'(m_tick[1]));
    chk("o.wrap", 32'(wrap1), 32'(m_wrap[1]));
    chk("o.done", 32'(done1), 32'(m_done[1]));
    chk("o.busy", 32'(busy1), 32'(m_mode[1] == 1));
    chk("o.step", 32'(step1), 32'(m_step[1]));
  endtask

  // Driver: one clock edge. Inputs are already stable, and outputs are
  // sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_phase[m] = 0; m_step[m] = 0; m_mode[m] = 0;
      m_tick[m] = 0;  m_wrap[m] = 0; m_done[m] = 0;
    end
    rst = 1'b0; run = 1'b1; clear = 1'b0; div = 8'd3; limit = 13'd4;

    // 1: reset held for two cycles while run is high
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst.tick", 32'(tick0), 32'd0);
      chk("rst.step", 32'(step0), 32'd0);
      chk("rst.busy", 32'(busy0), 32'd0);
      chk("rst.done1", 32'(done1), 32'd0);
    end

    // 2: wrap mode with div=3 and limit=4
    rst = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      chk("t2.tick", 32'(tick0), 32'((i % 3) == 0));
      chk("t2.busy", 32'(busy0), 32'd1);
      chk("t2.wrap", 32'(wrap0), 32'(i == 15));
      chk("t2.step", 32'(step0), 32'((i / 3) % 5));
    end

    // 3: pause after two advancing edges, then resume
    clear = 1'b1; cyc(); clear = 1'b0;
    div = 8'd4;
    cyc(); cyc();
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3.pause_tick", 32'(tick0), 32'd0);
      chk("t3.pause_step", 32'(step0), 32'd0);
      chk("t3.pause_busy", 32'(busy0), 32'd0);
    end
    run = 1'b1;
    cyc();
    chk("t3.res1_tick", 32'(tick0), 32'd0);
    cyc();
    chk("t3.res2_tick", 32'(tick0), 32'd1);
    chk("t3.res2_step", 32'(step0), 32'd1);

    // 4: one-shot with div=2 and limit=3
    clear = 1'b1; cyc(); clear = 1'b0;
    div = 8'd2; limit = 13'd3;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("t4.done", 32'(done1), 32'(i == 6));
    end
    chk("t4.step", 32'(step1), 32'd3);
    chk("t4.busy", 32'(busy1), 32'd0);
    chk("t4.tick6", 32'(tick1), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t4.hold_tick", 32'(tick1), 32'd0);
      chk("t4.hold_done", 32'(done1), 32'd1);
      chk("t4.hold_step", 32'(step1), 32'd3);
    end
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("t4.clr_step", 32'(step1), 32'd0);
    chk("t4.clr_done", 32'(done1), 32'd0);
    chk("t4.clr_busy", 32'(busy1), 32'd0);

    // 5: div=0 and limit=0, so a tick and a wrap on every cycle
    div = 8'd0; limit = 13'd0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t5.tick", 32'(tick0), 32'd1);
      chk("t5.wrap", 32'(wrap0), 32'd1);
      chk("t5.step", 32'(step0), 32'd0);
    end

    // 6: clear beats run mid-count, then reset at step 7
    clear = 1'b1; cyc(); clear = 1'b0;
    div = 8'd1; limit = 13'd20;
    for (int i = 0; i < 4; i++) cyc();
    chk("t6.pre_clr", 32'(step0), 32'd4);
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("t6.clr_step", 32'(step0), 32'd0);
    chk("t6.clr_busy", 32'(busy0), 32'd0);
    for (int i = 0; i < 7; i++) cyc();
    chk("t6.at7", 32'(step0), 32'd7);
    rst = 1'b0; cyc(); rst = 1'b1;
    chk("t6.rst_step", 32'(step0), 32'd0);
    chk("t6.rst_tick", 32'(tick0), 32'd0);
    chk("t6.rst_busy", 32'(busy0), 32'd0);
    div = 8'd3;
    cyc(); chk("t6.re1", 32'(tick0), 32'd0);
    cyc(); chk("t6.re2", 32'(tick0), 32'd0);
    cyc(); chk("t6.re3", 32'(tick0), 32'd1);
    chk("t6.re3_step", 32'(step0), 32'd1);

    // Randomized soak, including mid-run div and limit changes and a full-range limit
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) != 0);
      clear = ($urandom_range(0, 79) == 0);
      run   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) div = DIV_W'($urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 9) == 0) limit = {CNT_W{1'b1}};
        else limit = CNT_W'($urandom_range(0, 9));
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
